fifo_serializer: RTL and testbench
==================================

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 The block SHALL have parameter BITS, default 16, giving the FIFO word width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 4, giving the serial chunk width in bits; BITS SHALL be an integer multiple of OUT_W, and N = BITS/OUT_W.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 fifo_dout  input  BITS  head word of the upstream fifo_flops; valid whenever fifo_pndng=1.
REQ-006 fifo_pndng  input  1  upstream FIFO not empty.
REQ-007 fifo_pop  output  1  one-cycle pop strobe to the upstream FIFO; consumes the head word at that posedge.
REQ-008 ser_data  output  OUT_W  current chunk, MSB-first.
REQ-009 ser_valid  output  1  ser_data holds a valid chunk.
REQ-010 ser_ready  input  1  downstream accepts the chunk; a transfer occurs on a posedge with ser_valid=1 and ser_ready=1.
REQ-011 ser_last  output  1  high with ser_valid on the final chunk (index N-1) of a word.
REQ-012 busy  output  1  high while a word is held (state SEND).
REQ-013 word_cnt  output  16  count of fully transferred words.

Function
REQ-014 The block SHALL implement two states, IDLE and SEND, held in registers.
REQ-015 In IDLE, with fifo_pndng=1, the block SHALL drive fifo_pop=1 combinationally, capture fifo_dout into the shift register, clear the chunk index, and enter SEND at that posedge.
REQ-016 fifo_pop SHALL never be asserted while fifo_pndng=0, and SHALL never be high for more than one cycle per word.
REQ-017 In SEND, ser_valid SHALL be 1 and ser_data SHALL equal shift_reg[BITS-1 -: OUT_W].
REQ-018 On each transfer, the block SHALL shift the shift register left by OUT_W and increment the chunk index.
REQ-019 While ser_valid=1 and ser_ready=0, ser_data, ser_last and the chunk index SHALL hold stable.
REQ-020 ser_last SHALL be 1 exactly when the chunk index equals N-1 in SEND.
REQ-021 On the transfer of the last chunk, word_cnt SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-022 If fifo_pndng=1 on the last-chunk transfer, the block SHALL pop and load the next word in the same cycle and remain in SEND (no bubble); otherwise it SHALL return to IDLE.
REQ-023 In IDLE, ser_valid, ser_last and busy SHALL be 0, and ser_data SHALL be 0.
REQ-024 Latency: the first chunk of a word SHALL appear on ser_data in the cycle after its pop.
REQ-025 With ser_ready held at 1, N consecutive chunks SHALL be delivered in N consecutive cycles.

Reset
REQ-026 While rst=0, the block SHALL force state IDLE, and the shift register, chunk index, word_cnt, fifo_pop, ser_valid, ser_last, busy and ser_data SHALL all be 0, independent of clk.
REQ-027 Reset asserted mid-word SHALL discard the partially sent word; the block SHALL NOT re-pop or replay that word.
REQ-028 After rst deasserts, the block SHALL pop no earlier than the first posedge at which rst=1 and fifo_pndng=1.

Verification (BITS=16, OUT_W=4)
REQ-029 Single word: FIFO holds 0xA5C3, ser_ready=1 -> one fifo_pop; ser_data A,5,C,3 in 4 consecutive cycles; ser_last only on 3; word_cnt=1; then IDLE.
REQ-030 Backpressure: word 0x1234, ser_ready low 3 cycles on chunk 2 -> ser_data=2 held stable for those cycles, then 3,4; no extra pop.
REQ-031 Back-to-back: FIFO holds 0x1111 and 0x2222, ser_ready=1 -> 8 consecutive valid cycles 1,1,1,1,2,2,2,2; second pop in the same cycle as the first ser_last transfer.
REQ-032 Empty FIFO: fifo_pndng=0 for 20 cycles -> fifo_pop, ser_valid and busy remain 0.
REQ-033 Reset mid-word: rst pulsed low after chunk 1 of 0xBEEF -> all outputs 0 asynchronously; after release with the FIFO empty, no ser_valid and word_cnt=0.
REQ-034 Wrap: word_cnt preloaded (forced) to 0xFFFF, one word sent -> word_cnt=0x0000.

Source files
------------

// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if: upstream FIFO pop port plus downstream chunk stream handshake
interface fifo_serializer_if #(parameter int BITS = 16, parameter int OUT_W = 4);
  logic [BITS-1:0]  fifo_dout;
  logic             fifo_pndng;
  logic             fifo_pop;
  logic [OUT_W-1:0] ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  modport master(input fifo_dout, fifo_pndng, ser_ready, output fifo_pop, ser_data, ser_valid, ser_last);
  modport slave(output fifo_dout, fifo_pndng, ser_ready, input fifo_pop, ser_data, ser_valid, ser_last);
endinterface

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops BITS-wide words from a FIFO and streams them MSB-first as OUT_W chunks
module fifo_serializer #(
  parameter int BITS  = 16,
  parameter int OUT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  fifo_serializer_if.master   bus,
  output logic                busy,
  output logic [15:0]         word_cnt
);
  localparam int N  = BITS / OUT_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t          state;
  logic [BITS-1:0] shift_reg;
  logic [IW-1:0]   idx;
  logic            last, xfer, load;
  always_comb begin
    last = state == SEND && idx == IW'(N - 1);
    xfer = state == SEND && bus.ser_ready;
    // reload on the final transfer keeps the stream bubble-free
    load = rst && bus.fifo_pndng && (state == IDLE || (xfer && last));
  end
  assign bus.fifo_pop  = load;
  assign bus.ser_valid = state == SEND;
  assign bus.ser_last  = last;
  assign bus.ser_data  = state == SEND ? shift_reg[BITS-1 -: OUT_W] : '0;
  assign busy          = state == SEND;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      idx       <= '0;
      word_cnt  <= '0;
    end else begin
      if (load) begin
        shift_reg <= bus.fifo_dout;
        idx       <= '0;
        state     <= SEND;
      end else if (xfer) begin
        shift_reg <= shift_reg << OUT_W;
        idx       <= idx + IW'(1);
        if (last) state <= IDLE;
      end
      if (xfer && last) word_cnt <= word_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed stimulus with a chunk scoreboard checked by an independent monitor
module tb_fifo_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] word_cnt;
  logic [15:0] mem [64];
  int          wr = 0, rd = 0;
  logic [4:0]  exp_q [$];
  int          checks = 0, fails = 0;
  int          pops = 0, xfers = 0, valid_cycles = 0, run = 0, last_run = 0;
  logic        prev_pop = 1'b0, stall = 1'b0, hold_last = 1'b0;
  logic [3:0]  hold_data = '0;
  fifo_serializer_if #(.BITS(16), .OUT_W(4)) bus();
  fifo_serializer #(.BITS(16), .OUT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .word_cnt(word_cnt)
  );
  always #5 clk = ~clk;
  assign bus.fifo_pndng = rd != wr;
  assign bus.fifo_dout  = mem[rd[5:0]];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_word(input logic [15:0] w);
    mem[wr[5:0]] = w;
    wr++;
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, w[15-4*i -: 4]});
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || rd != wr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask
  // monitor samples mid-cycle, when inputs and outputs have settled before the next posedge
  always begin
    logic [4:0] e;
    @(negedge clk);
    #3;
    if (bus.fifo_pop) begin
      check("pop_with_pndng", 32'(bus.fifo_pndng), 32'd1);
      check("pop_single_cycle", 32'(prev_pop), 32'd0);
      if (bus.ser_valid) check("pop_on_last_xfer", 32'(bus.ser_last & bus.ser_ready), 32'd1);
      pops++;
    end
    if (bus.ser_valid) begin
      run++;
      valid_cycles++;
      check("busy_in_send", 32'(busy), 32'd1);
      if (stall) begin
        check("stall_data", 32'(bus.ser_data), 32'(hold_data));
        check("stall_last", 32'(bus.ser_last), 32'(hold_last));
      end
      if (bus.ser_ready) begin
        xfers++;
        if (exp_q.size() == 0) check("unexpected_chunk", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check("chunk_data", 32'(bus.ser_data), 32'(e[3:0]));
          check("chunk_last", 32'(bus.ser_last), 32'(e[4]));
        end
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
      check("idle_data", 32'(bus.ser_data), 32'd0);
      check("idle_last", 32'(bus.ser_last), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    stall     = bus.ser_valid && !bus.ser_ready;
    hold_data = bus.ser_data;
    hold_last = bus.ser_last;
    prev_pop  = bus.fifo_pop;
    if (bus.fifo_pop) begin
      @(posedge clk);
      #1;
      rd++;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, v0;
    logic found;
    rst = 1'b0;
    bus.ser_ready = 1'b1;
    // word queued while in reset must not be popped until release
    repeat (2) @(negedge clk);
    push_word(16'hA5C3);
    repeat (2) @(negedge clk);
    check("rst_pop", 32'(bus.fifo_pop), 32'd0);
    check("rst_valid", 32'(bus.ser_valid), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_no_pops", 32'(pops), 32'd0);
    rst = 1'b1;
    p0 = pops;
    wait_idle(50);
    check("single_pops", 32'(pops - p0), 32'd1);
    check("single_run", 32'(last_run), 32'd4);
    check("single_word_cnt", 32'(word_cnt), 32'd1);
    check("single_busy", 32'(busy), 32'd0);
    p0 = pops;
    found = 1'b0;
    push_word(16'h1234);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.ser_valid && bus.ser_data == 4'h2;
    end
    check("bp_chunk2_seen", 32'(found), 32'd1);
    bus.ser_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus.ser_ready = 1'b1;
    wait_idle(50);
    check("bp_pops", 32'(pops - p0), 32'd1);
    check("bp_word_cnt", 32'(word_cnt), 32'd2);
    p0 = pops;
    push_word(16'h1111);
    push_word(16'h2222);
    wait_idle(50);
    check("b2b_pops", 32'(pops - p0), 32'd2);
    check("b2b_run", 32'(last_run), 32'd8);
    check("b2b_word_cnt", 32'(word_cnt), 32'd4);
    p0 = pops;
    v0 = valid_cycles;
    repeat (20) @(negedge clk);
    check("empty_pops", 32'(pops - p0), 32'd0);
    check("empty_valid", 32'(valid_cycles - v0), 32'd0);
    push_word(16'hBEEF);
    v0 = xfers;
    for (int i = 0; i < 20 && xfers == v0; i++) @(negedge clk);
    check("rst_mid_chunk1", 32'(xfers - v0), 32'd1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("async_valid", 32'(bus.ser_valid), 32'd0);
    check("async_data", 32'(bus.ser_data), 32'd0);
    check("async_last", 32'(bus.ser_last), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_pop", 32'(bus.fifo_pop), 32'd0);
    check("async_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    p0 = pops;
    v0 = valid_cycles;
    repeat (10) @(negedge clk);
    check("post_rst_valid", 32'(valid_cycles - v0), 32'd0);
    check("post_rst_pops", 32'(pops - p0), 32'd0);
    check("post_rst_word_cnt", 32'(word_cnt), 32'd0);
    force dut.word_cnt = 16'hFFFF;
    #1;
    release dut.word_cnt;
    check("wrap_preload", 32'(word_cnt), 32'hFFFF);
    push_word(16'h0F0F);
    wait_idle(50);
    check("wrap_word_cnt", 32'(word_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
